// File: rtl/q_sample_fetcher_if.sv
// Transition, Q-table RAM and updater signals for q_sample_fetcher.
// Q_FETCH_ARGMAX_EN adds o_best_action.
interface q_sample_fetcher_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int STATE_BITS  = 4,
    parameter int ACTION_BITS = 2
);
    logic                              i_valid;
    logic [STATE_BITS-1:0]             i_state;
    logic [ACTION_BITS-1:0]            i_action;
    logic [STATE_BITS-1:0]             i_next_state;
    logic [DATA_WIDTH-1:0]             i_rt;
    logic                              o_ready;
    logic                              mem_ren;
    logic [STATE_BITS+ACTION_BITS-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0]             mem_rdata;
    logic                              mem_wen;
    logic [STATE_BITS+ACTION_BITS-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]             mem_wdata;
    logic                              o_valid;
    logic [DATA_WIDTH-1:0]             o_q;
    logic [DATA_WIDTH-1:0]             o_max_q;
    logic [DATA_WIDTH-1:0]             o_rt;
    logic                              i_q_new_valid;
    logic [DATA_WIDTH-1:0]             i_q_new;
    logic                              o_err;
`ifdef Q_FETCH_ARGMAX_EN
    logic [ACTION_BITS-1:0]            o_best_action;
`endif

    modport slave (
        input  i_valid, i_state, i_action, i_next_state, i_rt, mem_rdata,
               i_q_new_valid, i_q_new,
        output o_ready, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
               o_valid, o_q, o_max_q, o_rt, o_err
`ifdef Q_FETCH_ARGMAX_EN
        , o_best_action
`endif
    );

    modport master (
        output i_valid, i_state, i_action, i_next_state, i_rt, mem_rdata,
               i_q_new_valid, i_q_new,
        input  o_ready, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
               o_valid, o_q, o_max_q, o_rt, o_err
`ifdef Q_FETCH_ARGMAX_EN
        , o_best_action
`endif
    );
endinterface

// File: rtl/q_sample_fetcher.sv
// Q-learning fetch front end: reads Q(s,a) and the s' row, finds the FP max, writes q_new back.
// Q_FETCH_ARGMAX_EN adds the o_best_action output and its index register.
module q_sample_fetcher #(
    parameter int DATA_WIDTH  = 32,
    parameter int STATE_BITS  = 4,
    parameter int ACTION_BITS = 2
) (
    input logic              clk,
    input logic              rst_n,
    q_sample_fetcher_if.slave bus
);
    localparam int ADDR_W = STATE_BITS + ACTION_BITS;
    localparam int NUM_ACTIONS = 2**ACTION_BITS;
    localparam logic [ACTION_BITS-1:0] K_ONE  = ACTION_BITS'(1);
    localparam logic [ACTION_BITS-1:0] K_LAST = ACTION_BITS'(NUM_ACTIONS-1);

    typedef enum logic [2:0] {IDLE, RD_Q, RD_NEXT, DRAIN, ISSUE, WAIT_RES, WRITE} state_e;

    state_e                  state_q, state_d;
    logic [STATE_BITS-1:0]   s_q, s_d, sn_q, sn_d;
    logic [ACTION_BITS-1:0]  a_q, a_d, k_q, k_d;
    logic                    ren_q, ren_d, wen_q, wen_d, valid_q, valid_d, err_q, err_d;
    logic [ADDR_W-1:0]       raddr_q, raddr_d, waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, q_q, q_d, maxq_q, maxq_d, rt_q, rt_d;
    logic                    max_load, cmp_win;

    // Sign-magnitude compare; +0 and -0 are equal so the incumbent is kept.
    function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y);
        if (x[DATA_WIDTH-2:0] == '0 && y[DATA_WIDTH-2:0] == '0) return 1'b0;
        if (x[DATA_WIDTH-1] != y[DATA_WIDTH-1]) return !x[DATA_WIDTH-1];
        if (!x[DATA_WIDTH-1]) return x[DATA_WIDTH-2:0] > y[DATA_WIDTH-2:0];
        return x[DATA_WIDTH-2:0] < y[DATA_WIDTH-2:0];
    endfunction

    assign cmp_win = fp_gt(bus.mem_rdata, maxq_q);

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        a_d      = a_q;
        sn_d     = sn_q;
        k_d      = k_q;
        ren_d    = 1'b0;
        raddr_d  = raddr_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        valid_d  = 1'b0;
        q_d      = q_q;
        rt_d     = rt_q;
        max_load = 1'b0;
        err_d    = err_q | (bus.i_q_new_valid & (state_q != WAIT_RES));
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    s_d     = bus.i_state;
                    a_d     = bus.i_action;
                    sn_d    = bus.i_next_state;
                    rt_d    = bus.i_rt;
                    ren_d   = 1'b1;
                    raddr_d = {bus.i_state, bus.i_action};
                    state_d = RD_Q;
                end
            end
            RD_Q: begin
                ren_d   = 1'b1;
                raddr_d = {sn_q, ACTION_BITS'(0)};
                k_d     = '0;
                state_d = RD_NEXT;
            end
            RD_NEXT: begin
                // Read data lags by one: k=0 returns Q(s,a), k=1 returns Q(s',0), and so on.
                if (k_q == '0)         q_d = bus.mem_rdata;
                else if (k_q == K_ONE) max_load = 1'b1;
                else                   max_load = cmp_win;
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d     = k_q + K_ONE;
                    ren_d   = 1'b1;
                    raddr_d = {sn_q, k_q + K_ONE};
                end
            end
            DRAIN: begin
                max_load = cmp_win;
                k_d      = '0;
                valid_d  = 1'b1;
                state_d  = ISSUE;
            end
            ISSUE: state_d = WAIT_RES;
            WAIT_RES: begin
                if (bus.i_q_new_valid) begin
                    wen_d   = 1'b1;
                    waddr_d = {s_q, a_q};
                    wdata_d = bus.i_q_new;
                    state_d = WRITE;
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        maxq_d = max_load ? bus.mem_rdata : maxq_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            a_q     <= '0;
            sn_q    <= '0;
            k_q     <= '0;
            ren_q   <= 1'b0;
            raddr_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            q_q     <= '0;
            maxq_q  <= '0;
            rt_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            a_q     <= a_d;
            sn_q    <= sn_d;
            k_q     <= k_d;
            ren_q   <= ren_d;
            raddr_q <= raddr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            q_q     <= q_d;
            maxq_q  <= maxq_d;
            rt_q    <= rt_d;
            err_q   <= err_d;
        end
    end

`ifdef Q_FETCH_ARGMAX_EN
    logic [ACTION_BITS-1:0] best_q, best_d;

    // Word returned in RD_NEXT belongs to action k-1; DRAIN returns the last action.
    always_comb begin
        best_d = best_q;
        if (max_load) best_d = (state_q == DRAIN) ? K_LAST : k_q - K_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) best_q <= '0;
        else        best_q <= best_d;
    end

    assign bus.o_best_action = best_q;
`endif

    assign bus.o_ready   = (state_q == IDLE);
    assign bus.mem_ren   = ren_q;
    assign bus.mem_raddr = raddr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_q       = q_q;
    assign bus.o_max_q   = maxq_q;
    assign bus.o_rt      = rt_q;
    assign bus.o_err     = err_q;
endmodule

// File: tb/tb_q_sample_fetcher.sv
// Scoreboard bench for q_sample_fetcher: directed transitions, monitor checks o_valid and mem_wen events.
module tb_q_sample_fetcher;
    logic clk, rst_n;
    int   n_vec = 0, n_err = 0, ncyc = 0;

    q_sample_fetcher_if #(.DATA_WIDTH(32), .STATE_BITS(4), .ACTION_BITS(2)) bus ();
    q_sample_fetcher #(.DATA_WIDTH(32), .STATE_BITS(4), .ACTION_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { int cyc; logic [31:0] q; logic [31:0] mx; logic [31:0] rt; logic [1:0] best; } out_t;
    typedef struct { int cyc; logic [5:0] addr; logic [31:0] data; } wr_t;
    out_t exp_out[$];
    wr_t  exp_wr[$];
    logic [31:0] qtab [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only RAM model, one cycle latency.
    always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= qtab[bus.mem_raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial forever begin
        out_t eo;
        wr_t  ew;
        @(negedge clk);
        ncyc = ncyc + 1;
        if (bus.o_valid) begin
            if (exp_out.size() == 0) chk("unexpected_o_valid", 32'd1, 32'd0);
            else begin
                eo = exp_out.pop_front();
                chk("o_valid_cycle", ncyc, eo.cyc);
                chk("o_q", bus.o_q, eo.q);
                chk("o_max_q", bus.o_max_q, eo.mx);
                chk("o_rt", bus.o_rt, eo.rt);
`ifdef Q_FETCH_ARGMAX_EN
                chk("o_best_action", {30'd0, bus.o_best_action}, {30'd0, eo.best});
`endif
            end
        end
        if (bus.mem_wen) begin
            if (exp_wr.size() == 0) chk("unexpected_mem_wen", 32'd1, 32'd0);
            else begin
                ew = exp_wr.pop_front();
                chk("mem_wen_cycle", ncyc, ew.cyc);
                chk("mem_waddr", {26'd0, bus.mem_waddr}, {26'd0, ew.addr});
                chk("mem_wdata", bus.mem_wdata, ew.data);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_o_ready"}, {31'd0, bus.o_ready}, 32'd1);
        chk({tag, "_o_valid"}, {31'd0, bus.o_valid}, 32'd0);
        chk({tag, "_mem_ren"}, {31'd0, bus.mem_ren}, 32'd0);
        chk({tag, "_mem_wen"}, {31'd0, bus.mem_wen}, 32'd0);
        chk({tag, "_o_err"}, {31'd0, bus.o_err}, 32'd0);
        chk({tag, "_o_q"}, bus.o_q, 32'd0);
        chk({tag, "_o_max_q"}, bus.o_max_q, 32'd0);
        chk({tag, "_o_rt"}, bus.o_rt, 32'd0);
        chk({tag, "_mem_raddr"}, {26'd0, bus.mem_raddr}, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
`ifdef Q_FETCH_ARGMAX_EN
        chk({tag, "_best"}, {30'd0, bus.o_best_action}, 32'd0);
`endif
    endtask

    task automatic set_row(input logic [3:0] sn, input logic [31:0] v0, v1, v2, v3);
        qtab[{sn, 2'd0}] = v0;
        qtab[{sn, 2'd1}] = v1;
        qtab[{sn, 2'd2}] = v2;
        qtab[{sn, 2'd3}] = v3;
    endtask

    // Returns at posedge+1 after the accepting edge; acc is that edge's cycle number.
    task automatic accept(input logic [3:0] s, input logic [1:0] a, input logic [3:0] sn,
                          input logic [31:0] rt, output int acc);
        int w = 0;
        while (!bus.o_ready && w < 50) begin @(posedge clk); #1; w++; end
        chk("accept_o_ready", {31'd0, bus.o_ready}, 32'd1);
        bus.i_valid = 1'b1; bus.i_state = s; bus.i_action = a; bus.i_next_state = sn; bus.i_rt = rt;
        @(posedge clk);
        acc = ncyc;
        #1 bus.i_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [3:0] s, input logic [1:0] a, input logic [3:0] sn,
                           input logic [31:0] rt, input logic [31:0] eq, input logic [31:0] emx,
                           input logic [1:0] ebest, input logic [31:0] qnew, input bit busy);
        int acc;
        bit seen = 1'b0;
        out_t eo;
        wr_t  ew;
        accept(s, a, sn, rt, acc);
        eo.cyc = acc + 7; eo.q = eq; eo.mx = emx; eo.rt = rt; eo.best = ebest;
        exp_out.push_back(eo);
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.o_valid; end
        if (!seen) begin
            chk("o_valid_timeout", 32'd0, 32'd1);
            return;
        end
        if (busy) begin
            bus.i_valid = 1'b1; bus.i_state = 4'hF; bus.i_action = 2'd2;
            bus.i_next_state = 4'hE; bus.i_rt = 32'hCAFEF00D;
            repeat (4) begin
                @(posedge clk); #1;
                chk("busy_o_ready", {31'd0, bus.o_ready}, 32'd0);
                chk("busy_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
            end
            bus.i_valid = 1'b0;
            chk("busy_o_rt_held", bus.o_rt, rt);
        end
        @(posedge clk); #1;
        bus.i_q_new_valid = 1'b1; bus.i_q_new = qnew;
        @(posedge clk);
        ew.cyc = ncyc + 1; ew.addr = {s, a}; ew.data = qnew;
        exp_wr.push_back(ew);
        #1 bus.i_q_new_valid = 1'b0;
        chk("write_o_ready", {31'd0, bus.o_ready}, 32'd0);
        @(posedge clk); #1;
        chk("ready_after_write", {31'd0, bus.o_ready}, 32'd1);
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 64; i++) qtab[i] = 32'h0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_state = '0; bus.i_action = '0; bus.i_next_state = '0;
        bus.i_rt = '0; bus.i_q_new_valid = 1'b0; bus.i_q_new = '0;
        repeat (2) @(posedge clk);
        #1 check_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic fetch: max 2.0 at action 1
        qtab[{4'd3, 2'd1}] = 32'h3F800000;
        set_row(4'd5, 32'h3F000000, 32'h40000000, 32'hBF800000, 32'h3F800000);
        run_txn(4'd3, 2'd1, 4'd5, 32'h3F800000, 32'h3F800000, 32'h40000000, 2'd1, 32'h3FC00000, 1'b0);

        // All negative: -1.0 tie, lower index kept
        qtab[{4'd1, 2'd0}] = 32'h12345678;
        set_row(4'd6, 32'hC0000000, 32'hBF800000, 32'hC0400000, 32'hBF800000);
        run_txn(4'd1, 2'd0, 4'd6, 32'hC1200000, 32'h12345678, 32'hBF800000, 2'd1, 32'h11111111, 1'b0);

        // Signed zero, with i_valid held during WAIT_RES
        qtab[{4'd4, 2'd2}] = 32'hBF000000;
        set_row(4'd7, 32'h80000000, 32'h00000000, 32'hBF800000, 32'h80000000);
        run_txn(4'd4, 2'd2, 4'd7, 32'h3E000000, 32'hBF000000, 32'h80000000, 2'd0, 32'h22222222, 1'b1);

        // Stray result strobe in IDLE
        bus.i_q_new_valid = 1'b1; bus.i_q_new = 32'hDEADBEEF;
        @(posedge clk); #1 bus.i_q_new_valid = 1'b0;
        chk("stray_o_err", {31'd0, bus.o_err}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("stray_err_sticky", {31'd0, bus.o_err}, 32'd1);
        chk("stray_o_ready", {31'd0, bus.o_ready}, 32'd1);

        // Reset during RD_NEXT
        qtab[{4'd5, 2'd0}] = 32'h3E800000;
        set_row(4'd3, 32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000);
        accept(4'd5, 2'd0, 4'd3, 32'h40400000, acc);
        @(posedge clk); @(posedge clk); #1;
        chk("pre_reset_mem_ren", {31'd0, bus.mem_ren}, 32'd1);
        chk("pre_reset_o_q", bus.o_q, 32'h3E800000);
        rst_n = 1'b0;
        #1 check_reset("midreset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("post_reset_o_ready", {31'd0, bus.o_ready}, 32'd1);

        // Self-loop s == s'
        set_row(4'd2, 32'h3F800000, 32'hC0000000, 32'h40A00000, 32'h41200000);
        run_txn(4'd2, 2'd3, 4'd2, 32'h00000000, 32'h41200000, 32'h41200000, 2'd3, 32'h41300000, 1'b0);
        chk("final_o_err", {31'd0, bus.o_err}, 32'd0);

        repeat (5) @(posedge clk);
        #1;
        chk("pending_outputs", exp_out.size(), 32'd0);
        chk("pending_writes", exp_wr.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
